uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one UART_rs232_tx between NUM_REQ byte producers.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit sequencer.
// Frame FSM encoding, default byte width and pointer helper.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } tx_state_t;

   function automatic int unsigned rr_wrap(
      input int unsigned idx,
      input int unsigned n
   );
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or
// after rr_ptr, scanning upward with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      rr_ptr,
   output logic               win_vld,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [PW-1:0]      win_idx
);

   logic [PW-1:0] pos;

   always_comb begin
      win_vld = 1'b0;
      win_oh  = '0;
      win_idx = '0;
      pos     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = PW'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
         if (!win_vld && req[pos]) begin
            win_vld     = 1'b1;
            win_oh[pos] = 1'b1;
            win_idx     = pos;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter between
// NUM_REQ byte producers, with a SEND watchdog.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = UART_DATA_W,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                      clk,
   input  logic                      rst_n_a,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      transmitter_enable,
   output logic [DATA_W-1:0]         transmitter_data,
   input  logic                      transmitter_done,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   tx_state_t            state_q, state_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 terr_q, terr_d;

   logic                 win_vld;
   logic [NUM_REQ-1:0]   win_oh;
   logic [PW-1:0]        win_idx;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .win_vld (win_vld),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   always_ff @(posedge clk or negedge rst_n_a) begin
      if (!rst_n_a) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         terr_q   <= terr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      grant_d  = '0;
      data_d   = data_q;
      terr_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               grant_d = win_oh;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (win_oh[i]) begin
                     data_d = req_data[i*DATA_W +: DATA_W];
                  end
               end
               rr_ptr_d =
                  PW'(rr_wrap(32'(win_idx), NUM_REQ));
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            // done wins over a coincident terminal count
            if (transmitter_done) begin
               state_d = GAP;
            end else if (cnt_q == CNT_TC) begin
               terr_d  = 1'b1;
               state_d = GAP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
      endcase
   end

   assign grant              = grant_q;
   assign transmitter_enable = (state_q == SEND);
   assign transmitter_data   = data_q;
   assign busy               = (state_q != IDLE);
   assign timeout_err        = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: driver pushes predicted frames, monitor pops
// and compares on every grant and frame end.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 50;
   localparam int BUDGET = 2000;

   typedef struct {
      int       idx;
      logic [7:0] data;
      int       d;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n_a;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  grant;
   logic          transmitter_enable;
   logic [DW-1:0] transmitter_data;
   logic          transmitter_done;
   logic          busy;
   logic          timeout_err;

   exp_t exp_q[$];
   int   dly_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_ptr = 0;
   bit   stray_done = 1'b0;

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                (clk),
      .rst_n_a            (rst_n_a),
      .req                (req),
      .req_data           (req_data),
      .grant              (grant),
      .transmitter_enable (transmitter_enable),
      .transmitter_data   (transmitter_data),
      .transmitter_done   (transmitter_done),
      .busy               (busy),
      .timeout_err        (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: serve the pending set in round-robin order from m_ptr.
   task automatic model_push(input logic [N-1:0] mask,
                             input int fixed_data,
                             input int fixed_d);
      logic [N-1:0] m;
      exp_t e;
      int j;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            req_data[i*DW +: DW] = (fixed_data >= 0) ?
               8'(fixed_data) : 8'($urandom);
         end
      end
      m = mask;
      while (m != '0) begin
         j = 0;
         for (int k = 0; k < N; k++) begin
            if (m[(m_ptr + k) % N]) begin
               j = (m_ptr + k) % N;
               break;
            end
         end
         e.idx  = j;
         e.data = req_data[j*DW +: DW];
         if (fixed_d >= 0) e.d = fixed_d;
         else begin
            case ($urandom_range(0, 9))
               0: e.d = 0;
               1: e.d = TO;
               2: e.d = TO - 1;
               3: e.d = TO + 1;
               default: e.d = $urandom_range(1, 30);
            endcase
         end
         exp_q.push_back(e);
         dly_q.push_back(e.d);
         m_ptr = (j + 1) % N;
         m[j] = 1'b0;
      end
   endtask

   task automatic drive_burst(input logic [N-1:0] mask,
                              input bit abort);
      bit ok = 1'b0;
      int sends = 0;
      req = mask;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
               req[i] = 1'b0;
               req_data[i*DW +: DW] = 8'($urandom);
            end
         end
         if (abort && transmitter_enable) sends++;
         if (abort ? (sends == 10) : (req == '0 && !busy)) begin
            ok = 1'b1;
            break;
         end
      end
      chk("burst_complete", 32'(ok), 32'd1);
   endtask

   // Transmitter stand-in: done after d SEND cycles, d==0 never.
   initial begin
      bit active = 1'b0;
      int c = 0;
      int d = 0;
      transmitter_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n_a) begin
            active = 1'b0;
            transmitter_done = 1'b0;
         end else if (transmitter_enable) begin
            if (!active) begin
               active = 1'b1;
               c = 0;
               d = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            end
            c++;
            transmitter_done = (d != 0 && c == d);
         end else begin
            active = 1'b0;
            transmitter_done = stray_done;
         end
      end
   end

   initial begin
      exp_t cur;
      int en_cnt = 0;
      bit seen_terr = 0, data_bad = 0, in_frame = 0;
      bit prev_en = 0, post_gap = 0, terr;
      cur = '{idx: 0, data: 8'h0, d: 0};
      forever begin
         @(negedge clk);
         if (!rst_n_a) begin
            in_frame = 0;
            prev_en  = 0;
            post_gap = 0;
         end else begin
            if (post_gap) begin
               chk("gap_one_cycle_busy", 32'(busy), 32'd0);
               chk("gap_no_grant", 32'(grant), 32'd0);
               post_gap = 0;
            end else if (grant != '0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", 32'(grant), 32'd0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("grant_index", 32'(grant), 32'd1 << cur.idx);
                  chk("latched_data", 32'(transmitter_data),
                      32'(cur.data));
                  chk("load_enable_low", 32'(transmitter_enable),
                      32'd0);
                  in_frame  = 1;
                  en_cnt    = 0;
                  seen_terr = 0;
                  data_bad  = 0;
               end
            end
            if (transmitter_enable) begin
               en_cnt++;
               if (transmitter_data !== cur.data) data_bad = 1;
            end
            if (timeout_err && !in_frame)
               chk("stray_timeout", 32'(timeout_err), 32'd0);
            if (timeout_err) seen_terr = 1;
            if (in_frame && prev_en && !transmitter_enable) begin
               terr = (cur.d == 0 || cur.d > TO);
               chk("timeout_err", 32'(seen_terr), 32'(terr));
               chk("send_length", 32'(en_cnt),
                   terr ? 32'(TO) : 32'(cur.d));
               chk("data_stable", 32'(data_bad), 32'd0);
               chk("gap_busy", 32'(busy), 32'd1);
               in_frame = 0;
               post_gap = 1;
            end
            prev_en = transmitter_enable;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_a  = 1'b0;
      req      = '0;
      req_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_enable", 32'(transmitter_enable), 32'd0);
      chk("rst_data", 32'(transmitter_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      rst_n_a = 1'b1;
      repeat (2) @(negedge clk);

      model_push(4'b1111, -1, 5);
      drive_burst(4'b1111, 1'b0);
      model_push(4'b1111, -1, 3);
      drive_burst(4'b1111, 1'b0);
      model_push(4'b0001, -1, 4);
      drive_burst(4'b0001, 1'b0);
      model_push(4'b1001, -1, 6);
      drive_burst(4'b1001, 1'b0);
      model_push(4'b0100, 8'hA5, 8);
      drive_burst(4'b0100, 1'b0);
      model_push(4'b0010, -1, 0);
      drive_burst(4'b0010, 1'b0);
      model_push(4'b1000, -1, TO);
      drive_burst(4'b1000, 1'b0);

      stray_done = 1'b1;
      repeat (2) @(negedge clk);
      stray_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stray_done_busy", 32'(busy), 32'd0);
         chk("stray_done_grant", 32'(grant), 32'd0);
      end

      for (int b = 0; b < 30; b++) begin
         logic [N-1:0] mask;
         mask = N'($urandom_range(1, 15));
         model_push(mask, -1, -1);
         drive_burst(mask, 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      model_push(4'b0001, -1, 0);
      drive_burst(4'b0001, 1'b1);
      #1 rst_n_a = 1'b0;
      #1;
      chk("async_rst_enable", 32'(transmitter_enable), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      m_ptr = 0;
      repeat (2) @(negedge clk);
      #1 rst_n_a = 1'b1;
      @(negedge clk);
      model_push(4'b0010, -1, 5);
      drive_burst(4'b0010, 1'b0);

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
